ov7725_capture: RTL and testbench
=================================

Name: ov7725_capture

Overview:
- Captures the OV7725 parallel DVP pixel stream once the SCCB configuration stage has asserted init_done.
- Assembles byte pairs into RGB565 pixels and discards the first WAIT_FRAME frames while the sensor settles.
- Produces registered frame-sync, pixel-valid and pixel-coordinate outputs for the downstream LCD/frame-buffer write path.
- Sits directly downstream of the camera SCCB driver and runs in the camera pixel-clock domain.

Parameters:
- WAIT_FRAME, 10: number of complete frames (vsync rising edges after init) discarded before output is enabled; range 1..15.
- H_MAX, 11'd2047: saturation limit of the pixel (x) and line (y) counters.

Ports:
- clk  input  1  camera pixel clock (cam_pclk); all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- init_done  input  1  SCCB configuration complete; asynchronous to clk.
- cam_vsync  input  1  sensor frame sync, active-high.
- cam_href  input  1  sensor line valid, active-high.
- cam_data  input  8  sensor data byte.
- frame_vsync  output  1  gated, registered copy of cam_vsync.
- frame_href  output  1  gated, registered copy of cam_href.
- frame_valid  output  1  one-cycle strobe: frame_data holds a complete pixel.
- frame_data  output  16  RGB565 pixel; first byte in [15:8], second byte in [7:0].
- pix_x  output  11  column index of the pixel on frame_data.
- pix_y  output  11  line index of the pixel on frame_data.
- byte_err  output  1  sticky flag: a line ended on an odd byte count.

Behaviour:
- Reset: every register is 0, so all outputs are 0. Reset asserted mid-frame aborts capture and restarts the frame-skip count from 0.
- init_done passes through a 2-flop synchroniser to give init_s. While init_s = 0:
  - the frame counter holds 0;
  - all outputs stay 0.
- Input registration: cam_vsync, cam_href and cam_data are registered once (vsync_d, href_d, data_d).
- Edge detection:
  - vs_rise = cam_vsync & ~vsync_d;
  - hs_fall = ~cam_href & href_d.
- Frame skip:
  - 4-bit frame_cnt increments on vs_rise when init_s = 1 and frame_cnt < WAIT_FRAME.
  - frame_ok is a register set when frame_cnt == WAIT_FRAME; it stays set until reset.
  - Output gating switches only on vs_rise, so output never starts mid-frame.
- Sync outputs: frame_vsync = frame_ok & vsync_d and frame_href = frame_ok & href_d. Both have 1-cycle latency relative to the cam inputs.
- Byte pairing:
  - byte_sel toggles on every cycle where cam_href = 1 and clears when cam_href = 0.
  - When byte_sel = 0, cam_data is latched as the high byte.
  - When byte_sel = 1, frame_data <= {high, cam_data} and frame_valid <= frame_ok.
  - Timing: byte A at cycle n (href = 1) and byte B at cycle n+1 give frame_valid = 1 at cycle n+2 with frame_data = {A, B}.
  - frame_valid is never high on two consecutive cycles.
  - frame_data holds its last value when frame_valid = 0.
- Coordinates:
  - pix_x and pix_y are registered together with frame_data.
  - The internal x counter increments after each pixel, clears on hs_fall and saturates at H_MAX.
  - The internal y counter increments on hs_fall, clears on vs_rise and saturates at H_MAX.
  - The first pixel of a frame reports (0,0).
- Odd-byte line end: if hs_fall occurs with byte_sel = 1, the trailing byte is dropped and no pixel is emitted. byte_err is set when frame_ok = 1 and clears on the next vs_rise.
- Simultaneous vs_rise and hs_fall: the y counter clears (clear wins over increment).
- If init_done deasserts after frame_ok is set, capture continues. Only rst restarts the skip sequence.

Test Plan:
- Reset/idle: rst = 1 for 3 cycles with random cam inputs -> all outputs 0. init_done = 0 for 5 frames -> frame_vsync, frame_valid and frame_cnt stay 0.
- Frame skip: WAIT_FRAME = 2, init_done = 1, 3 frames of 4 lines x 8 bytes -> frames 1–2 produce no frame_valid. Frame 3 produces exactly 16 frame_valid pulses and frame_vsync toggles.
- Byte pairing/latency: href bytes 0xF8, 0x1F, 0x07, 0xE0 -> frame_valid at byte0 + 2 cycles with 0xF81F (pix_x = 0), then 2 cycles later 0x07E0 (pix_x = 1).
- Coordinates: 3 lines x 4 pixels after skip -> final pixel reports pix_x = 3, pix_y = 2. The next frame's first pixel reports (0,0).
- Odd line: line of 5 bytes -> 2 pixels emitted, byte_err = 1. byte_err stays 1 until the next cam_vsync rising edge, then returns to 0.
- Mid-frame reset: pulse rst = 1 for one cycle during frame 4 -> outputs drop to 0 next cycle. Capture resumes only after 2 further vs_rise events (WAIT_FRAME = 2).

Source files
------------

// File: rtl/ov7725_capture.sv
// OV7725 DVP capture: skips the first WAIT_FRAME frames after SCCB init, then pairs
// bytes into RGB565 pixels and emits registered sync, pixel-valid and coordinates.
// Single clock domain (camera pclk), synchronous active-high reset.
module ov7725_capture #(
  parameter int unsigned WAIT_FRAME = 10,
  parameter logic [10:0] H_MAX      = 11'd2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        frame_vsync,
  output logic        frame_href,
  output logic        frame_valid,
  output logic [15:0] frame_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        byte_err
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_FRAME);

  typedef enum logic [0:0] {StSkip, StRun} state_e;

  state_e      state_q, state_d;
  logic        init_meta_q, init_s_q;
  logic        vsync_q, href_q;
  logic [7:0]  data_q;
  logic [3:0]  frame_cnt_q;
  logic        byte_sel_q;
  logic [10:0] x_cnt_q, y_cnt_q;
  logic        frame_vsync_q, frame_href_q, frame_valid_q, byte_err_q;
  logic [15:0] frame_data_q;
  logic [10:0] pix_x_q, pix_y_q;

  logic vs_rise, hs_fall, pix_done;
  logic frame_ok, frame_ok_nxt, cnt_inc;

  assign vs_rise  = cam_vsync & ~vsync_q;
  assign hs_fall  = ~cam_href & href_q;
  // Second byte of a pair arrives this cycle; the first one sits in data_q.
  assign pix_done = cam_href & byte_sel_q;

  // Two-flop synchroniser for the SCCB-domain init flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_meta_q <= 1'b0;
      init_s_q    <= 1'b0;
    end else begin
      init_meta_q <= init_done;
      init_s_q    <= init_meta_q;
    end
  end

  // One-stage registration of the raw sensor inputs for edge detection and pairing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      data_q  <= cam_data;
    end
  end

  // Frame-skip FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSkip;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter the run state on the vsync edge that follows the last discarded frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSkip: begin
        if (init_s_q && vs_rise && (frame_cnt_q == WaitCnt)) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StSkip;
    endcase
  end

  // FSM-derived gating and counter enable.
  always_comb begin
    frame_ok     = (state_q == StRun);
    frame_ok_nxt = (state_d == StRun);
    cnt_inc      = (state_q == StSkip) && init_s_q && vs_rise && (frame_cnt_q < WaitCnt);
  end

  // Count discarded frames; holds while init is not yet seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 4'd0;
    end else if (cnt_inc) begin
      frame_cnt_q <= frame_cnt_q + 4'd1;
    end
  end

  // Byte phase within a line: 0 = high byte expected, 1 = low byte expected.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_sel_q <= 1'b0;
    end else begin
      byte_sel_q <= cam_href ? ~byte_sel_q : 1'b0;
    end
  end

  // Column counter: advances per pixel, clears at line end, saturates at H_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_q <= 11'd0;
    end else if (hs_fall || vs_rise) begin
      x_cnt_q <= 11'd0;
    end else if (pix_done && (x_cnt_q != H_MAX)) begin
      x_cnt_q <= x_cnt_q + 11'd1;
    end
  end

  // Line counter: advances at line end, clears at frame start (clear wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      y_cnt_q <= 11'd0;
    end else if (vs_rise) begin
      y_cnt_q <= 11'd0;
    end else if (hs_fall && (y_cnt_q != H_MAX)) begin
      y_cnt_q <= y_cnt_q + 11'd1;
    end
  end

  // Gated sync outputs and the pixel strobe, one cycle behind the sensor inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_vsync_q <= 1'b0;
      frame_href_q  <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_vsync_q <= frame_ok_nxt & cam_vsync;
      frame_href_q  <= frame_ok_nxt & cam_href;
      frame_valid_q <= pix_done & frame_ok;
    end
  end

  // Pixel data and coordinates update together and hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_data_q <= 16'h0000;
      pix_x_q      <= 11'd0;
      pix_y_q      <= 11'd0;
    end else if (pix_done && frame_ok) begin
      frame_data_q <= {data_q, cam_data};
      pix_x_q      <= x_cnt_q;
      pix_y_q      <= y_cnt_q;
    end
  end

  // Sticky odd-byte-line flag, cleared at the start of every frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_err_q <= 1'b0;
    end else if (vs_rise) begin
      byte_err_q <= 1'b0;
    end else if (hs_fall && byte_sel_q && frame_ok) begin
      byte_err_q <= 1'b1;
    end
  end

  assign frame_vsync = frame_vsync_q;
  assign frame_href  = frame_href_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign byte_err    = byte_err_q;

endmodule

// File: tb/tb_ov7725_capture.sv
// Self-checking bench for ov7725_capture (WAIT_FRAME = 2): cycle tables for reset and
// byte-pairing latency, plus a pixel scoreboard fed by the frame generator.
module tb_ov7725_capture;

  logic        clk = 1'b0;
  logic        rst, init_done, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        frame_vsync, frame_href, frame_valid, byte_err;
  logic [15:0] frame_data;
  logic [10:0] pix_x, pix_y;

  always #5 clk = ~clk;

  ov7725_capture #(
    .WAIT_FRAME(2),
    .H_MAX     (11'd2047)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_vsync(frame_vsync),
    .frame_href (frame_href),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .byte_err   (byte_err)
  );

  typedef struct {
    logic        r;
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        e_vs;
    logic        e_hs;
    logic        e_val;
    logic [15:0] e_data;
    logic [10:0] e_x;
    logic [10:0] e_y;
    logic        e_err;
    logic        chk;  // compare data/coordinates on this row
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [10:0] x;
    logic [10:0] y;
  } px_t;

  px_t         sb_q[$];
  vec_t        rst_tab[3];
  vec_t        lat_tab[8];
  int          checks = 0;
  int          failures = 0;
  bit          sb_en = 1'b0;
  logic        prev_valid = 1'b0;
  int          valid_cnt = 0;
  int          vs_hi_cnt = 0;
  logic [10:0] last_x, last_y, first_x, first_y;
  bit          first_seen = 1'b0;

  function automatic vec_t mk(logic r, logic vs, logic hr, logic [7:0] d, logic evs, logic ehs,
                              logic evl, logic [15:0] edt, logic [10:0] ex, logic [10:0] ey,
                              logic eerr, logic chk);
    vec_t v;
    v.r = r; v.vs = vs; v.hr = hr; v.d = d;
    v.e_vs = evs; v.e_hs = ehs; v.e_val = evl; v.e_data = edt;
    v.e_x = ex; v.e_y = ey; v.e_err = eerr; v.chk = chk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected pixel.
  task automatic monitor();
    px_t e;
    if (frame_vsync === 1'b1) vs_hi_cnt++;
    if (frame_valid === 1'b1) begin
      valid_cnt++;
      check("valid_gap", {31'd0, prev_valid}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("px_data", {16'd0, frame_data}, {16'd0, e.data});
        check("px_x", {21'd0, pix_x}, {21'd0, e.x});
        check("px_y", {21'd0, pix_y}, {21'd0, e.y});
      end
      last_x = pix_x;
      last_y = pix_y;
      if (!first_seen) begin
        first_x    = pix_x;
        first_y    = pix_y;
        first_seen = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, then sample on the following falling edge.
  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    @(negedge clk);
    if (sb_en) monitor();
    prev_valid = frame_valid;
  endtask

  task automatic apply_vec(input int idx, input string tag, input vec_t v);
    rst = v.r;
    step(v.vs, v.hr, v.d);
    check($sformatf("%s%0d_vsync", tag, idx), {31'd0, frame_vsync}, {31'd0, v.e_vs});
    check($sformatf("%s%0d_href", tag, idx), {31'd0, frame_href}, {31'd0, v.e_hs});
    check($sformatf("%s%0d_valid", tag, idx), {31'd0, frame_valid}, {31'd0, v.e_val});
    check($sformatf("%s%0d_err", tag, idx), {31'd0, byte_err}, {31'd0, v.e_err});
    if (v.chk) begin
      check($sformatf("%s%0d_data", tag, idx), {16'd0, frame_data}, {16'd0, v.e_data});
      check($sformatf("%s%0d_x", tag, idx), {21'd0, pix_x}, {21'd0, v.e_x});
      check($sformatf("%s%0d_y", tag, idx), {21'd0, pix_y}, {21'd0, v.e_y});
    end
  endtask

  // One frame: vsync pulse, then lines of bytes separated by href gaps.
  task automatic send_frame(input int lines, input int bpl, input int first_bpl,
                            input bit expect_px);
    logic [7:0] d, hi;
    int         nb;
    px_t        p;
    hi = 8'h00;
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      nb = (l == 0) ? first_bpl : bpl;
      for (int b = 0; b < nb; b++) begin
        d = 8'($urandom_range(0, 255));
        if ((b % 2) == 0) begin
          hi = d;
        end else if (expect_px) begin
          p.data = {hi, d};
          p.x    = 11'(b / 2);
          p.y    = 11'(l);
          sb_q.push_back(p);
        end
        step(1'b0, 1'b1, d);
      end
      repeat (3) step(1'b0, 1'b0, 8'h00);
    end
    repeat (2) step(1'b0, 1'b0, 8'h00);
  endtask

  int p0, v0;

  initial begin
    rst = 1'b1; init_done = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;

    for (int i = 0; i < 3; i++) begin
      rst_tab[i] = mk(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 0, 0, 0, 16'h0000, 11'd0, 11'd0, 0, 1);
    end
    //              r  vs hr d      vs hs vl data      x      y      err chk
    lat_tab[0] = mk(0, 1, 0, 8'h00, 1, 0, 0, 16'h0000, 11'd0, 11'd0, 0, 0);
    lat_tab[1] = mk(0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 11'd0, 11'd0, 0, 0);
    lat_tab[2] = mk(0, 0, 1, 8'hF8, 0, 1, 0, 16'h0000, 11'd0, 11'd0, 0, 0);
    lat_tab[3] = mk(0, 0, 1, 8'h1F, 0, 1, 1, 16'hF81F, 11'd0, 11'd0, 0, 1);
    lat_tab[4] = mk(0, 0, 1, 8'h07, 0, 1, 0, 16'hF81F, 11'd0, 11'd0, 0, 1);
    lat_tab[5] = mk(0, 0, 1, 8'hE0, 0, 1, 1, 16'h07E0, 11'd1, 11'd0, 0, 1);
    lat_tab[6] = mk(0, 0, 0, 8'h00, 0, 0, 0, 16'h07E0, 11'd1, 11'd0, 0, 1);
    lat_tab[7] = mk(0, 0, 0, 8'h00, 0, 0, 0, 16'h07E0, 11'd1, 11'd0, 0, 1);

    @(negedge clk);
    // Reset with random sensor activity.
    for (int i = 0; i < 3; i++) apply_vec(i, "rst", rst_tab[i]);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // No init: frames must be ignored completely.
    sb_en = 1'b1;
    repeat (5) send_frame(4, 8, 8, 1'b0);
    check("noinit_vsync_cycles", vs_hi_cnt, 0);
    check("noinit_valid_count", valid_cnt, 0);
    check("noinit_frame_cnt", {28'd0, dut.frame_cnt_q}, 0);

    // Init, two discarded frames, then capture.
    init_done = 1'b1;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    p0 = valid_cnt; v0 = vs_hi_cnt;
    send_frame(4, 8, 8, 1'b0);
    send_frame(4, 8, 8, 1'b0);
    check("skip_valid_count", valid_cnt - p0, 0);
    check("skip_vsync_cycles", vs_hi_cnt - v0, 0);
    p0 = valid_cnt; v0 = vs_hi_cnt;
    send_frame(4, 8, 8, 1'b1);
    check("run_valid_count", valid_cnt - p0, 16);
    check("run_vsync_cycles", vs_hi_cnt - v0, 3);
    check("run_sb_empty", sb_q.size(), 0);

    // Byte-pairing latency table.
    sb_en = 1'b0;
    for (int i = 0; i < 8; i++) apply_vec(i, "lat", lat_tab[i]);
    sb_en = 1'b1;

    // Coordinates: last pixel of a 3x4 frame, then first pixel of the next.
    send_frame(3, 8, 8, 1'b1);
    check("coord_last_x", {21'd0, last_x}, 3);
    check("coord_last_y", {21'd0, last_y}, 2);
    first_seen = 1'b0;
    send_frame(3, 8, 8, 1'b1);
    check("coord_first_seen", {31'd0, first_seen}, 1);
    check("coord_first_x", {21'd0, first_x}, 0);
    check("coord_first_y", {21'd0, first_y}, 0);

    // Odd-length first line: trailing byte dropped, sticky error until next vsync edge.
    p0 = valid_cnt;
    send_frame(2, 4, 5, 1'b1);
    check("odd_valid_count", valid_cnt - p0, 4);
    check("odd_sb_empty", sb_q.size(), 0);
    check("odd_err_held", {31'd0, byte_err}, 1);
    step(1'b1, 1'b0, 8'h00);
    check("odd_err_cleared", {31'd0, byte_err}, 0);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    send_frame(2, 8, 8, 1'b1);
    check("after_odd_err", {31'd0, byte_err}, 0);

    // Mid-frame reset.
    sb_en = 1'b0;
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAA);
    check("mr_href_before", {31'd0, frame_href}, 1);
    step(1'b0, 1'b1, 8'hBB);
    check("mr_valid_before", {31'd0, frame_valid}, 1);
    check("mr_data_before", {16'd0, frame_data}, 32'h0000AABB);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'hCC);
    rst = 1'b0;
    check("mr_vsync", {31'd0, frame_vsync}, 0);
    check("mr_href", {31'd0, frame_href}, 0);
    check("mr_valid", {31'd0, frame_valid}, 0);
    check("mr_data", {16'd0, frame_data}, 0);
    check("mr_x", {21'd0, pix_x}, 0);
    check("mr_y", {21'd0, pix_y}, 0);
    check("mr_err", {31'd0, byte_err}, 0);
    step(1'b0, 1'b1, 8'hDD);
    check("mr_href_after", {31'd0, frame_href}, 0);
    step(1'b0, 1'b1, 8'hEE);
    check("mr_valid_after", {31'd0, frame_valid}, 0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    sb_en = 1'b1;
    p0 = valid_cnt;
    send_frame(4, 8, 8, 1'b0);
    send_frame(4, 8, 8, 1'b0);
    check("mr_skip_valid_count", valid_cnt - p0, 0);
    p0 = valid_cnt;
    send_frame(4, 8, 8, 1'b1);
    check("mr_resume_valid_count", valid_cnt - p0, 16);
    check("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
